// File: rtl/div_pipe_pkg.sv
// rtl/div_pipe_pkg.sv - shared types, constants and helpers for the pipelined divider
//
// Purpose: default geometry, latency helper and the per-stage control record
// carried alongside the datapath through every pipeline register.
// Data fields (partial remainder, quotient, divisor magnitude) depend on the
// divider parameters, so they travel as separate parameter-sized vectors next
// to this record.
package div_pipe_pkg;

    localparam int DEF_N   = 8;
    localparam int DEF_BPS = 1;
    localparam int ITER    = DEF_N / DEF_BPS;

    // Total latency from accept to result: conditioning + iterations + sign fix.
    function automatic int div_lat(input int n, input int bps);
        return n / bps + 2;
    endfunction

    typedef struct packed {
        logic valid;
        logic sign_q;   // negate quotient at the output
        logic sign_r;   // negate remainder at the output
        logic dbz;      // divisor was zero
    } stage_ctl_t;

endpackage

// File: rtl/div_pipe_stage.sv
// rtl/div_pipe_stage.sv - one restoring iteration stage retiring BPS quotient bits
//
// Purpose: BPS restoring steps followed by the stage register.
// Ports:
//   clk_i, rst_n_i   clock, asynchronous active-low reset
//   adv_i            global pipeline advance; the register loads only when high
//   ctl_i / ctl_o    control record in / registered out
//   rem_i / rem_o    partial remainder (M bits between stages)
//   quo_i / quo_o    combined register: unconsumed dividend bits at the top,
//                    developed quotient bits shifted in at the bottom
//   div_i / div_o    divisor magnitude
module div_pipe_stage
    import div_pipe_pkg::*;
#(
    parameter int N   = 8,
    parameter int M   = 8,
    parameter int BPS = 1
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             adv_i,
    input  stage_ctl_t       ctl_i,
    input  logic [M-1:0]     rem_i,
    input  logic [N-1:0]     quo_i,
    input  logic [M-1:0]     div_i,
    output stage_ctl_t       ctl_o,
    output logic [M-1:0]     rem_o,
    output logic [N-1:0]     quo_o,
    output logic [M-1:0]     div_o
);

    logic [M:0]   trial;
    logic [M-1:0] rem_v;
    logic [N-1:0] quo_v;

    stage_ctl_t   ctl_d, ctl_q;
    logic [M-1:0] rem_d, rem_q;
    logic [N-1:0] quo_d, quo_q;
    logic [M-1:0] div_d, div_q;

    // Trial value is M+1 bits: the shifted remainder can reach 2*|d|-1.
    // After a successful subtraction the result is below |d| and fits M bits,
    // so the subtraction is done modulo 2^M.
    always_comb begin
        rem_v = rem_i;
        quo_v = quo_i;
        trial = '0;
        for (int s = 0; s < BPS; s++) begin
            trial = {rem_v, quo_v[N-1]};
            quo_v = {quo_v[N-2:0], 1'b0};
            if (trial >= {1'b0, div_i}) begin
                rem_v    = trial[M-1:0] - div_i;
                quo_v[0] = 1'b1;
            end else begin
                rem_v = trial[M-1:0];
            end
        end
    end

    always_comb begin
        ctl_d = ctl_q;
        rem_d = rem_q;
        quo_d = quo_q;
        div_d = div_q;
        if (adv_i) begin
            ctl_d = ctl_i;
            rem_d = rem_v;
            quo_d = quo_v;
            div_d = div_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ctl_q <= '0;
            rem_q <= '0;
            quo_q <= '0;
            div_q <= '0;
        end else begin
            ctl_q <= ctl_d;
            rem_q <= rem_d;
            quo_q <= quo_d;
            div_q <= div_d;
        end
    end

    assign ctl_o = ctl_q;
    assign rem_o = rem_q;
    assign quo_o = quo_q;
    assign div_o = div_q;

endmodule

// File: rtl/div_pipe.sv
// rtl/div_pipe.sv - pipelined signed/unsigned integer divider with ready/valid flow control
//
// Purpose: restoring divider, N/BPS + 2 cycle latency, one result per cycle,
// truncating toward zero. Optional macro DIV_PIPE_DBZ_EN adds dbz_o.
// Ports:
//   clk_i, rst_n_i          clock, asynchronous active-low reset
//   valid_i / ready_o       input handshake (ready_o is the global advance)
//   signed_i                per-transaction two's complement mode
//   dividend_i, divisor_i   operands (N / M bits)
//   valid_o / ready_i       output handshake
//   quotient_o, remainder_o results (N / M bits)
//   dbz_o                   divisor was zero (DIV_PIPE_DBZ_EN only)
module div_pipe
    import div_pipe_pkg::*;
#(
    parameter int N   = 8,
    parameter int M   = 8,
    parameter int BPS = 1
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         valid_i,
    output logic         ready_o,
    input  logic         signed_i,
    input  logic [N-1:0] dividend_i,
    input  logic [M-1:0] divisor_i,
    output logic         valid_o,
    input  logic         ready_i,
    output logic [N-1:0] quotient_o,
`ifdef DIV_PIPE_DBZ_EN
    output logic [M-1:0] remainder_o,
    output logic         dbz_o
`else
    output logic [M-1:0] remainder_o
`endif
);

    localparam int NSTG = N / BPS;

    if ((N % BPS) != 0 || M > N || M < 2 || N < 2) begin : g_bad_cfg
        $fatal(1, "div_pipe: illegal N/M/BPS combination");
    end

    // Whole pipe moves together; bubbles are not squeezed out.
    logic adv;
    logic valid_q;
    assign adv     = !valid_q | ready_i;
    assign ready_o = adv;

    // ---------------- input conditioning stage ----------------
    // An N-bit unsigned register holds |most negative| (2^(N-1)) exactly,
    // so no extra magnitude bit is needed past this point.
    logic         a_neg, b_neg, b_zero;
    logic [N-1:0] a_mag;
    logic [M-1:0] b_mag;

    stage_ctl_t   in_ctl_d, in_ctl_q;
    logic [N-1:0] in_quo_d, in_quo_q;
    logic [M-1:0] in_div_d, in_div_q;

    always_comb begin
        a_neg  = signed_i & dividend_i[N-1];
        b_neg  = signed_i & divisor_i[M-1];
        b_zero = (divisor_i == '0);
        a_mag  = a_neg ? -dividend_i : dividend_i;
        b_mag  = b_neg ? -divisor_i : divisor_i;

        in_ctl_d = in_ctl_q;
        in_quo_d = in_quo_q;
        in_div_d = in_div_q;
        if (adv) begin
            in_ctl_d.valid  = valid_i;
            // Zero divisor always yields an all-ones quotient, never negated.
            in_ctl_d.sign_q = (a_neg ^ b_neg) & !b_zero;
            in_ctl_d.sign_r = a_neg;
`ifdef DIV_PIPE_DBZ_EN
            in_ctl_d.dbz    = b_zero;
`else
            in_ctl_d.dbz    = 1'b0;
`endif
            in_quo_d = a_mag;
            in_div_d = b_mag;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            in_ctl_q <= '0;
            in_quo_q <= '0;
            in_div_q <= '0;
        end else begin
            in_ctl_q <= in_ctl_d;
            in_quo_q <= in_quo_d;
            in_div_q <= in_div_d;
        end
    end

    // ---------------- iteration stages ----------------
    stage_ctl_t   ctl_c [NSTG+1];
    logic [M-1:0] rem_c [NSTG+1];
    logic [N-1:0] quo_c [NSTG+1];
    logic [M-1:0] div_c [NSTG+1];

    assign ctl_c[0] = in_ctl_q;
    assign rem_c[0] = '0;
    assign quo_c[0] = in_quo_q;
    assign div_c[0] = in_div_q;

    for (genvar g = 0; g < NSTG; g++) begin : g_stage
        div_pipe_stage #(
            .N   (N),
            .M   (M),
            .BPS (BPS)
        ) u_stage (
            .clk_i   (clk_i),
            .rst_n_i (rst_n_i),
            .adv_i   (adv),
            .ctl_i   (ctl_c[g]),
            .rem_i   (rem_c[g]),
            .quo_i   (quo_c[g]),
            .div_i   (div_c[g]),
            .ctl_o   (ctl_c[g+1]),
            .rem_o   (rem_c[g+1]),
            .quo_o   (quo_c[g+1]),
            .div_o   (div_c[g+1])
        );
    end

    // ---------------- sign fix / output stage ----------------
    stage_ctl_t   last_ctl;
    logic         valid_d;
    logic [N-1:0] quotient_d, quotient_q;
    logic [M-1:0] remainder_d, remainder_q;

    assign last_ctl = ctl_c[NSTG];

    always_comb begin
        valid_d     = valid_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        if (adv) begin
            valid_d     = last_ctl.valid;
            quotient_d  = last_ctl.sign_q ? -quo_c[NSTG] : quo_c[NSTG];
            remainder_d = last_ctl.sign_r ? -rem_c[NSTG] : rem_c[NSTG];
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            valid_q     <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
        end else begin
            valid_q     <= valid_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
        end
    end

    assign valid_o     = valid_q;
    assign quotient_o  = quotient_q;
    assign remainder_o = remainder_q;

`ifdef DIV_PIPE_DBZ_EN
    logic dbz_d, dbz_q;

    always_comb begin
        dbz_d = dbz_q;
        if (adv) begin
            dbz_d = last_ctl.valid & last_ctl.dbz;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            dbz_q <= 1'b0;
        end else begin
            dbz_q <= dbz_d;
        end
    end

    assign dbz_o = dbz_q;
`else
    // Flag is tied off in this build; the divisor magnitude of the last stage
    // is also only needed inside the iteration chain.
    logic unused_ok;
    assign unused_ok = ^{last_ctl.dbz, div_c[NSTG]};
`endif

endmodule

// File: tb/tb_div_pipe.sv
// tb/tb_div_pipe.sv - self-checking bench for div_pipe (N=8, M=8, BPS=1)
module tb_div_pipe;

    logic       clk = 1'b0;
    logic       rst_n_i = 1'b0;
    logic       valid_i = 1'b0;
    logic       ready_o;
    logic       signed_i = 1'b0;
    logic [7:0] dividend_i = '0;
    logic [7:0] divisor_i = '0;
    logic       valid_o;
    logic       ready_i = 1'b1;
    logic [7:0] quotient_o;
    logic [7:0] remainder_o;
`ifdef DIV_PIPE_DBZ_EN
    logic       dbz_o;
`endif

    div_pipe #(.N(8), .M(8), .BPS(1)) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n_i),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .signed_i    (signed_i),
        .dividend_i  (dividend_i),
        .divisor_i   (divisor_i),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .quotient_o  (quotient_o),
`ifdef DIV_PIPE_DBZ_EN
        .remainder_o (remainder_o),
        .dbz_o       (dbz_o)
`else
        .remainder_o (remainder_o)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference model: truncating division in 32-bit arithmetic, zero-divisor
    // gives all-ones quotient and dividend low bits as remainder.
    function automatic logic [16:0] model(input logic s, input logic [7:0] a, input logic [7:0] b);
        int ia, ib, iq, ir;
        logic [7:0] q, r;
        if (b == 8'h00) begin
            return {1'b1, 8'hFF, a};
        end
        ia = s ? int'($signed(a)) : int'(a);
        ib = s ? int'($signed(b)) : int'(b);
        iq = ia / ib;
        ir = ia % ib;
        q  = iq[7:0];
        r  = ir[7:0];
        return {1'b0, q, r};
    endfunction

    // ---------------- scoreboard monitor ----------------
    logic [16:0] exp_q[$];
    bit          mon_en = 0;
    int          cyc_cnt = 0;
    int          out_cnt, out_first, out_last;
    bit          stall_prev = 0;
    logic [16:0] held;

    always @(posedge clk) cyc_cnt++;

    always @(negedge clk) begin
        logic [16:0] e;
        if (mon_en && rst_n_i) begin
            chk("ready_adv", ready_o, !valid_o | ready_i);
            if (stall_prev) chk("stall_hold", {valid_o, quotient_o, remainder_o}, held);
            if (valid_o && ready_i) begin
                if (exp_q.size() == 0) begin
                    chk("extra_result", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rnd_q", quotient_o, e[15:8]);
                    chk("rnd_r", remainder_o, e[7:0]);
`ifdef DIV_PIPE_DBZ_EN
                    chk("rnd_dbz", dbz_o, e[16]);
`endif
                    out_cnt++;
                    if (out_cnt == 1) out_first = cyc_cnt;
                    out_last = cyc_cnt;
                end
            end
            stall_prev = valid_o & !ready_i;
            held = {valid_o, quotient_o, remainder_o};
        end else begin
            stall_prev = 0;
        end
    end

    // ---------------- directed single transaction ----------------
    task automatic run_one(input string tag, input logic s, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] eq, input logic [7:0] er, input logic ed);
        int cyc;
        @(posedge clk); #1;
        valid_i = 1; signed_i = s; dividend_i = a; divisor_i = b;
        @(posedge clk); #1;
        valid_i = 0;
        cyc = 1;
        while (cyc < 30) begin
            @(negedge clk);
            if (valid_o) break;
            @(posedge clk);
            cyc++;
        end
        chk({tag, "_lat"}, cyc, 10);
        chk({tag, "_q"}, quotient_o, eq);
        chk({tag, "_r"}, remainder_o, er);
`ifdef DIV_PIPE_DBZ_EN
        chk({tag, "_dbz"}, dbz_o, ed);
`else
        if (ed) chk({tag, "_nodbz_data"}, {quotient_o, remainder_o}, {eq, er});
`endif
        @(posedge clk);
    endtask

    task automatic new_op();
        signed_i   = 1'($urandom_range(0, 1));
        dividend_i = 8'($urandom);
        divisor_i  = ($urandom_range(0, 15) == 0) ? 8'h00 : 8'($urandom);
    endtask

    task automatic drive_rand(input int cnt, input bit rand_ready);
        int   sent;
        logic acc;
        sent = 0;
        @(posedge clk); #1;
        new_op();
        valid_i = 1;
        ready_i = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        while (sent < cnt) begin
            @(negedge clk);
            acc = ready_o;
            if (acc) exp_q.push_back(model(signed_i, dividend_i, divisor_i));
            @(posedge clk); #1;
            if (acc) begin
                sent++;
                if (sent < cnt) new_op();
                else valid_i = 0;
            end
            ready_i = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        ready_i = 1;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        chk(tag, exp_q.size(), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation timed out");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        #12;
        chk("rst_valid", valid_o, 0);
        chk("rst_q", quotient_o, 0);
        chk("rst_r", remainder_o, 0);
`ifdef DIV_PIPE_DBZ_EN
        chk("rst_dbz", dbz_o, 0);
`endif
        @(posedge clk); #1;
        rst_n_i = 1;

        run_one("s7_m2",    1, 8'h07, 8'hFE, 8'hFD, 8'h01, 0);
        run_one("sm7_2",    1, 8'hF9, 8'h02, 8'hFD, 8'hFF, 0);
        run_one("u200_7",   0, 8'hC8, 8'h07, 8'h1C, 8'h04, 0);
        run_one("s_ovf",    1, 8'h80, 8'hFF, 8'h80, 8'h00, 0);
        run_one("u93_0",    0, 8'h5D, 8'h00, 8'hFF, 8'h5D, 1);
        run_one("sm93_0",   1, 8'hA3, 8'h00, 8'hFF, 8'hA3, 1);
        run_one("u255_1",   0, 8'hFF, 8'h01, 8'hFF, 8'h00, 0);
        run_one("sm128_127",1, 8'h80, 8'h7F, 8'hFF, 8'hFF, 0);
        run_one("u255_255", 0, 8'hFF, 8'hFF, 8'h01, 8'h00, 0);
        run_one("s127_m128",1, 8'h7F, 8'h80, 8'h00, 8'h7F, 0);

        // Back-to-back, consumer always ready.
        mon_en = 1;
        out_cnt = 0;
        drive_rand(128, 0);
        drain("a_drain");
        chk("a_count", out_cnt, 128);
        chk("a_span", out_last - out_first + 1, 128);

        // Random backpressure.
        out_cnt = 0;
        drive_rand(64, 1);
        drain("b_drain");
        chk("b_count", out_cnt, 64);

        // Reset with transactions in flight and a result at the output.
        mon_en = 0;
        @(posedge clk); #1;
        valid_i = 1;
        repeat (12) begin
            new_op();
            @(posedge clk); #1;
        end
        valid_i = 0;
        chk("rst_pre_valid", valid_o, 1);
        #1;
        rst_n_i = 0;
        #1;
        chk("rst_mid_valid", valid_o, 0);
        chk("rst_mid_q", quotient_o, 0);
        chk("rst_mid_r", remainder_o, 0);
        @(posedge clk); #1;
        rst_n_i = 1;
        seen = 0;
        repeat (15) begin
            @(negedge clk);
            if (valid_o) seen++;
        end
        chk("rst_dropped", seen, 0);
        run_one("post_rst", 1, 8'h07, 8'hFE, 8'hFD, 8'h01, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
